// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit: opcodes, sweep FSM states and
// the bitwise gate function used by both the datapath and the sweep engine.
package logic_gate_pkg;

   localparam logic [2:0] OP_NAND = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NOT  = 3'b110;
   localparam logic [2:0] OP_BUF  = 3'b111;

   typedef enum logic [1:0] {
      SW_IDLE = 2'd0,
      SW_RUN  = 2'd1,
      SW_DONE = 2'd2
   } sweep_state_e;

   // Evaluated at the widest legal operand width; callers truncate to WIDTH.
   function automatic logic [31:0] gate_eval(input logic [2:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] y;
      y = '0;
      case (op)
         OP_NAND: y = ~(a & b);
         OP_AND:  y =   a & b;
         OP_OR:   y =   a | b;
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y =   a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         OP_BUF:  y =   a;
         default: y = '0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/logic_gate_unit_gate_bank.sv
// Combinational WIDTH-bit gate bank; one instance is shared between the
// normal operand path and the exhaustive sweep counter.
module gate_bank
   import logic_gate_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o
);

   assign y_o = WIDTH'(gate_eval(op_i, 32'(a_i), 32'(b_i)));

endmodule

// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit gate bank with valid/ready handshake and an optional
// exhaustive sweep engine that accumulates a popcount signature.
module logic_gate_unit
   import logic_gate_pkg::*;
#(
   parameter  int WIDTH    = 4,
   parameter  bit SWEEP_EN = 1'b1,
   // clog2(WIDTH * 2^(2*WIDTH)) + 1 written so it cannot overflow at WIDTH=32
   localparam int SW       = 2 * WIDTH + $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic [SW-1:0]    sweep_sig
);

   logic             accept;
   logic             out_valid_q;
   logic [WIDTH-1:0] y_q;

   logic             sweep_run;
   logic [2:0]       sweep_op;
   logic [WIDTH-1:0] sweep_a;
   logic [WIDTH-1:0] sweep_b;

   logic [2:0]       bank_op;
   logic [WIDTH-1:0] bank_a;
   logic [WIDTH-1:0] bank_b;
   logic [WIDTH-1:0] bank_y;

   assign in_ready = !sweep_busy && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      bank_op = op;
      bank_a  = A;
      bank_b  = B;
      if (sweep_run) begin
         bank_op = sweep_op;
         bank_a  = sweep_a;
         bank_b  = sweep_b;
      end
   end

   gate_bank #(.WIDTH(WIDTH)) u_gate_bank (
      .op_i (bank_op),
      .a_i  (bank_a),
      .b_i  (bank_b),
      .y_o  (bank_y)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         y_q         <= bank_y;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign Y         = y_q;

   generate
      if (SWEEP_EN) begin : g_sweep
         localparam logic [2*WIDTH-1:0] CNT_LAST = '1;

         sweep_state_e       state_q;
         logic [2*WIDTH-1:0] cnt_q;
         logic [2:0]         op_q;
         logic [SW-1:0]      sig_q;
         logic               busy_q;
         logic               done_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q <= SW_IDLE;
               cnt_q   <= '0;
               op_q    <= OP_NAND;
               sig_q   <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end else begin
               case (state_q)
                  SW_IDLE: begin
                     // A start that collides with a pending result or an accept is dropped.
                     if (sweep_start && !out_valid_q && !accept) begin
                        state_q <= SW_RUN;
                        busy_q  <= 1'b1;
                        op_q    <= op;
                        cnt_q   <= '0;
                        sig_q   <= '0;
                     end
                  end
                  SW_RUN: begin
                     sig_q <= sig_q + SW'($countones(bank_y));
                     if (cnt_q == CNT_LAST) begin
                        state_q <= SW_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
                  SW_DONE: begin
                     state_q <= SW_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b0;
                  end
                  default: begin
                     state_q <= SW_IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b0;
                  end
               endcase
            end
         end

         assign sweep_run  = (state_q == SW_RUN);
         assign sweep_op   = op_q;
         assign sweep_a    = cnt_q[2*WIDTH-1:WIDTH];
         assign sweep_b    = cnt_q[WIDTH-1:0];
         assign sweep_busy = busy_q;
         assign sweep_done = done_q;
         assign sweep_sig  = sig_q;
      end else begin : g_no_sweep
         assign sweep_run  = 1'b0;
         assign sweep_op   = OP_NAND;
         assign sweep_a    = '0;
         assign sweep_b    = '0;
         assign sweep_busy = 1'b0;
         assign sweep_done = 1'b0;
         assign sweep_sig  = '0;
      end
   endgenerate

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit: gate truth vectors, handshake
// backpressure, sweep signatures at WIDTH=4 and WIDTH=1, and reset mid-sweep.
module tb_logic_gate_unit;
   import logic_gate_pkg::*;

   localparam int W4  = 4;
   localparam int SW4 = 2 * W4 + $clog2(W4) + 1;
   localparam int W1  = 1;
   localparam int SW1 = 2 * W1 + $clog2(W1) + 1;

   logic           clk;
   logic           rst_n;

   logic           in_valid, in_ready, out_valid, out_ready;
   logic [2:0]     op;
   logic [W4-1:0]  a, b, y;
   logic           sweep_start, sweep_busy, sweep_done;
   logic [SW4-1:0] sweep_sig;

   logic           in_valid1, in_ready1, out_valid1, out_ready1;
   logic [2:0]     op1;
   logic [W1-1:0]  a1, b1, y1;
   logic           sweep_start1, sweep_busy1, sweep_done1;
   logic [SW1-1:0] sweep_sig1;

   int checks   = 0;
   int failures = 0;

   logic_gate_unit #(.WIDTH(W4), .SWEEP_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .op(op), .A(a), .B(b),
      .out_valid(out_valid), .out_ready(out_ready), .Y(y),
      .sweep_start(sweep_start), .sweep_busy(sweep_busy),
      .sweep_done(sweep_done), .sweep_sig(sweep_sig)
   );

   logic_gate_unit #(.WIDTH(W1), .SWEEP_EN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1), .op(op1), .A(a1), .B(b1),
      .out_valid(out_valid1), .out_ready(out_ready1), .Y(y1),
      .sweep_start(sweep_start1), .sweep_busy(sweep_busy1),
      .sweep_done(sweep_done1), .sweep_sig(sweep_sig1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one WIDTH=4 sweep; the opcode is changed and in_valid raised mid-sweep.
   task automatic run_sweep4(input string tag, input logic [2:0] sop, input int exp_sig);
      int busy_cycles;
      int done_cnt;
      int sig_at_done;
      int guard;
      busy_cycles = 0;
      done_cnt    = 0;
      sig_at_done = 0;
      guard       = 0;
      op          = sop;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      op          = ~sop;
      in_valid    = 1'b1;
      while (sweep_busy && guard < 1000) begin
         busy_cycles++;
         if (sweep_done) begin
            done_cnt++;
            sig_at_done = 32'(sweep_sig);
         end
         if (busy_cycles == 100) check({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
         tick();
         guard++;
      end
      in_valid = 1'b0;
      check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd257);
      check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, "_sig_at_done"}, 32'(sig_at_done), 32'(exp_sig));
      check({tag, "_sig_hold"}, 32'(sweep_sig), 32'(exp_sig));
      check({tag, "_done_low"}, 32'(sweep_done), 32'd0);
      check({tag, "_no_out_valid"}, 32'(out_valid), 32'd0);
   endtask

   logic [W4-1:0] exp_y [8];
   int            busy1;
   int            done1;
   int            guard1;
   int            seen;

   initial begin
      exp_y[0] = 4'b0111; exp_y[1] = 4'b1000; exp_y[2] = 4'b1110; exp_y[3] = 4'b0001;
      exp_y[4] = 4'b0110; exp_y[5] = 4'b1001; exp_y[6] = 4'b0011; exp_y[7] = 4'b1100;

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b1; op = OP_NAND; a = '0; b = '0; sweep_start = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b1; op1 = OP_NAND; a1 = '0; b1 = '0; sweep_start1 = 1'b0;

      tick();
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_busy", 32'(sweep_busy), 32'd0);
      check("rst_done", 32'(sweep_done), 32'd0);
      check("rst_sig", 32'(sweep_sig), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Back-to-back beats through all eight functions.
      a = 4'b1100;
      b = 4'b1010;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         tick();
         check($sformatf("op%0d_y", i), 32'(y), 32'(exp_y[i]));
         check($sformatf("op%0d_valid", i), 32'(out_valid), 32'd1);
      end

      op = OP_OR;
      out_ready = 1'b0;
      #1;
      check("bp_in_ready_pre", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("bp%0d_y", i), 32'(y), 32'b1100);
         check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("drain_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("drain_accept_y", 32'(y), 32'b1110);
      check("drain_accept_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      check("drain_empty", 32'(out_valid), 32'd0);

      // Accept and sweep_start together: accept wins.
      in_valid = 1'b1;
      op = OP_AND;
      sweep_start = 1'b1;
      tick();
      in_valid = 1'b0;
      sweep_start = 1'b0;
      check("collide_busy", 32'(sweep_busy), 32'd0);
      check("collide_y", 32'(y), 32'b1000);
      check("collide_valid", 32'(out_valid), 32'd1);

      // Start while a result is stalled is ignored, not queued.
      out_ready = 1'b0;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      check("stalled_start_busy", 32'(sweep_busy), 32'd0);
      check("stalled_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      tick();
      check("stalled_drain", 32'(out_valid), 32'd0);
      check("stalled_no_late_start", 32'(sweep_busy), 32'd0);

      run_sweep4("sweep_nand", OP_NAND, 768);
      run_sweep4("sweep_xor", OP_XOR, 512);

      // WIDTH=1 NAND sweep: truth table 1,1,1,0.
      op1 = OP_NAND;
      sweep_start1 = 1'b1;
      tick();
      sweep_start1 = 1'b0;
      busy1 = 0;
      done1 = 0;
      guard1 = 0;
      while (sweep_busy1 && guard1 < 100) begin
         busy1++;
         if (sweep_done1) done1++;
         tick();
         guard1++;
      end
      check("w1_busy_cycles", 32'(busy1), 32'd5);
      check("w1_done_pulses", 32'(done1), 32'd1);
      check("w1_sig", 32'(sweep_sig1), 32'd3);

      // Reset in the middle of a sweep.
      op = OP_NAND;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      repeat (40) tick();
      check("mid_busy", 32'(sweep_busy), 32'd1);
      check("mid_sig_nonzero", 32'(sweep_sig != '0), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(sweep_busy), 32'd0);
      check("arst_sig", 32'(sweep_sig), 32'd0);
      check("arst_done", 32'(sweep_done), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_y", 32'(y), 32'd0);
      tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (300) begin
         tick();
         if (sweep_done || sweep_busy) seen = 1;
      end
      check("arst_no_resume", 32'(seen), 32'd0);

      run_sweep4("sweep_and", OP_AND, 256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
